i2c_slave_read_resp: RTL
========================

Name: i2c_slave_read_resp

Overview:
- I2C slave responder for the master-receive (random-read) transaction.
- Decodes START, the device address with W, and a one-byte data address. It then decodes a repeated START and the device address with R, and shifts register data back to the master MSB-first.
- Sits on the SCL/SDA pins opposite the I2C master receiver. Data comes from a local register bank through a 1-cycle-latency read port.
- Runs on the 50 MHz system clock and oversamples SCL/SDA.

Parameters:
- DEV_ADDR, 7'h50, 7-bit slave address the block responds to.
- SYNC_STAGES, 2, flop stages on the SCL/SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous active-high reset.
- i_scl  input  1  I2C clock from the master.
- i_sda  input  1  sampled value of the SDA pad.
- o_sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release to Z.
- o_rd_en  output  1  one-cycle read strobe to the register bank.
- o_rd_addr  output  8  register address for the read.
- i_rd_data  input  8  register data, valid 1 clk after o_rd_en.
- o_addr_hit  output  1  one-cycle pulse when the device address matches.
- o_busy  output  1  high from START to STOP.
- o_slave_state  output  2  00 = idle/receive, 01 = ACK drive, 10 = data transmit, 11 = master ACK check.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the address register is 8'h00.
- Reset mid-transfer also releases SDA immediately on the next clk.
- Inputs:
  - Pass through the SYNC_STAGES synchronizer, then one more delay flop for edge detection.
  - scl_rise and scl_fall are derived from the synchronized SCL.
- Bus conditions (evaluated every clk, in any state):
  - START / repeated START: synchronized SDA falls while SCL is high. Go to ADDR with bit counter = 0.
  - STOP: synchronized SDA rises while SCL is high. Go to IDLE and release SDA.
  - START or STOP takes priority over any data-bit event in the same clk.
- Timing rules:
  - Bits are sampled on scl_rise.
  - o_sda_oe changes only on scl_fall, taking effect 1 clk after the detected fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits, then R/W).
    - Mismatch: go to IDLE and never drive SDA for the rest of the transfer.
    - Match: pulse o_addr_hit and go to ACK_A.
  - ACK_A: on the next scl_fall, drive SDA low for one SCL period and release on the following scl_fall.
    - If R/W = 0, go to REG.
    - If R/W = 1, go to TX.
    - On entry to TX, pulse o_rd_en with o_rd_addr = the address register.
  - REG: shift 8 bits into the address register, then go to ACK_R, which drives ACK exactly as ACK_A does.
    - After ACK_R, go to WAIT_RS.
    - Any further write bytes are ACKed and ignored.
  - WAIT_RS: wait for a repeated START (to ADDR) or a STOP (to IDLE).
  - TX:
    - The byte is latched from i_rd_data 1 clk after o_rd_en.
    - On each scl_fall, present the next bit: o_sda_oe = ~bit.
    - The MSB is presented on the scl_fall that ends the ACK.
    - After the 8th bit's scl_fall, release SDA and go to MACK.
  - MACK: sample SDA on scl_rise.
    - 0 (ACK): the master wants more. Fetch the next byte and return to TX.
    - 1 (NACK): release SDA and go to WAIT_RS.
- The bit counter is 3 bits and wraps 7 -> 0 at a byte boundary.
- The address register is 8 bits and wraps modulo 256.
- SCL stretching is not supported. The master's SCL period must be at least 8 clk.

Optional Feature:
- Macro: I2C_SLV_AUTOINC_EN.
- Defined: the address register increments by 1 after each byte acknowledged in MACK, so the next o_rd_addr is addr+1. 8'hFF wraps to 8'h00.
- Not defined: the address is held, so repeated master ACKs re-read the same register.

Test Plan:
- Address ACK: START, 0xA0 (0x50 with W) -> o_addr_hit pulses once; o_sda_oe = 1 for the 9th SCL period.
- Single read: write data address 0x3C, repeated START, 0xA1, register bank returns 0x5A, master NACK -> o_rd_addr = 0x3C; master receives 0x5A; state returns to WAIT_RS; STOP -> o_busy = 0.
- Address mismatch: device address 0x51 with W -> no ACK; o_sda_oe stays 0 until STOP; o_rd_en is never asserted.
- Burst read at 0xFE, master ACKs twice then NACKs:
  - With I2C_SLV_AUTOINC_EN: addresses are 0xFE, 0xFF, 0x00.
  - Without it: all three reads are at 0xFE.
- Abort: STOP during the 4th data bit of TX -> SDA released within 1 clk; state goes to IDLE; a new transfer completes normally.
- Reset mid-transfer: rst asserted for 1 clk while in ACK_R -> all outputs 0 on the next clk, SDA released, state IDLE.

Source files
------------

// File: rtl/i2c_slave_read_resp.sv
// I2C slave responder for random-read transactions: decodes address/W + data address, then Sr + address/R, and returns register data.
// Optional feature macro I2C_SLV_AUTOINC_EN: increment the register address after each master-ACKed byte.
module i2c_slave_read_resp #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_rd_en,
    output logic [7:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_addr_hit,
    output logic       o_busy,
    output logic [1:0] o_slave_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        ACK_A   = 3'd2,
        REG     = 3'd3,
        ACK_R   = 3'd4,
        WAIT_RS = 3'd5,
        TX      = 3'd6,
        MACK    = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic scl_d_reg, sda_d_reg;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       phase_reg, phase_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] tx_reg, tx_next;
    logic [7:0] addr_reg, addr_next;
    logic       rw_reg, rw_next;
    logic       ign_wr_reg, ign_wr_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       rd_en_reg, rd_en_next;
    logic       rd_pend_reg, rd_pend_next;
    logic       addr_hit_reg, addr_hit_next;
    logic       busy_reg, busy_next;
    logic [7:0] rx_byte;

    // Synchronizers idle high so reset never fabricates a bus event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], i_scl};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], i_sda};
            scl_d_reg    <= scl_s;
            sda_d_reg    <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_reg;
    assign scl_fall  = ~scl_s & scl_d_reg;
    assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;
    assign rx_byte   = {shift_reg[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            phase_reg    <= 1'b0;
            shift_reg    <= 8'h00;
            tx_reg       <= 8'h00;
            addr_reg     <= 8'h00;
            rw_reg       <= 1'b0;
            ign_wr_reg   <= 1'b0;
            sda_oe_reg   <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_pend_reg  <= 1'b0;
            addr_hit_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            addr_reg     <= addr_next;
            rw_reg       <= rw_next;
            ign_wr_reg   <= ign_wr_next;
            sda_oe_reg   <= sda_oe_next;
            rd_en_reg    <= rd_en_next;
            rd_pend_reg  <= rd_pend_next;
            addr_hit_reg <= addr_hit_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        phase_next    = phase_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        addr_next     = addr_reg;
        rw_next       = rw_reg;
        ign_wr_next   = ign_wr_reg;
        sda_oe_next   = sda_oe_reg;
        rd_en_next    = 1'b0;
        rd_pend_next  = rd_en_reg;
        addr_hit_next = 1'b0;
        busy_next     = busy_reg;

        if (rd_pend_reg) begin
            tx_next = i_rd_data;
        end

        if (start_det) begin
            state_next  = ADDR;
            cnt_next    = 3'd0;
            phase_next  = 1'b0;
            ign_wr_next = 1'b0;
            sda_oe_next = 1'b0;
            busy_next   = 1'b1;
        end else if (stop_det) begin
            state_next  = IDLE;
            ign_wr_next = 1'b0;
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else begin
            case (state_reg)
                ADDR: begin
                    if (scl_rise) begin
                        shift_next = rx_byte;
                        cnt_next   = cnt_reg + 3'd1;
                        if (cnt_reg == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                addr_hit_next = 1'b1;
                                rw_next       = rx_byte[0];
                                phase_next    = 1'b0;
                                state_next    = ACK_A;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
                // phase 0: drive ACK on the fall ending bit 8; phase 1: ACK is on the bus.
                // For a read, the fetch starts on the ACK rise so the MSB is ready for the closing fall.
                ACK_A, ACK_R: begin
                    if (!phase_reg) begin
                        if (scl_fall) begin
                            sda_oe_next = 1'b1;
                            phase_next  = 1'b1;
                        end
                    end else if (state_reg == ACK_A && rw_reg) begin
                        if (scl_rise) begin
                            state_next = TX;
                            rd_en_next = 1'b1;
                            cnt_next   = 3'd0;
                            phase_next = 1'b0;
                        end
                    end else if (scl_fall) begin
                        sda_oe_next = 1'b0;
                        phase_next  = 1'b0;
                        cnt_next    = 3'd0;
                        ign_wr_next = (state_reg == ACK_R);
                        state_next  = (state_reg == ACK_A) ? REG : WAIT_RS;
                    end
                end
                REG: begin
                    if (scl_rise) begin
                        shift_next = rx_byte;
                        cnt_next   = cnt_reg + 3'd1;
                        if (cnt_reg == 3'd7) begin
                            addr_next  = rx_byte;
                            phase_next = 1'b0;
                            state_next = ACK_R;
                        end
                    end
                end
                WAIT_RS: begin
                    // Surplus write bytes are counted so they still receive an ACK.
                    if (ign_wr_reg && scl_rise) begin
                        cnt_next = cnt_reg + 3'd1;
                        if (cnt_reg == 3'd7) begin
                            phase_next = 1'b0;
                            state_next = ACK_R;
                        end
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (phase_reg) begin
                            sda_oe_next = 1'b0;
                            phase_next  = 1'b0;
                            state_next  = MACK;
                        end else begin
                            sda_oe_next = ~tx_reg[7];
                            tx_next     = {tx_reg[6:0], 1'b0};
                            cnt_next    = cnt_reg + 3'd1;
                            phase_next  = (cnt_reg == 3'd7);
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
`ifdef I2C_SLV_AUTOINC_EN
                            addr_next = addr_reg + 8'd1;
`else
                            addr_next = addr_reg;
`endif
                            rd_en_next = 1'b1;
                            cnt_next   = 3'd0;
                            phase_next = 1'b0;
                            state_next = TX;
                        end else begin
                            sda_oe_next = 1'b0;
                            ign_wr_next = 1'b0;
                            state_next  = WAIT_RS;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        case (state_reg)
            ACK_A, ACK_R: o_slave_state = 2'b01;
            TX:           o_slave_state = 2'b10;
            MACK:         o_slave_state = 2'b11;
            default:      o_slave_state = 2'b00;
        endcase
    end

    assign o_sda_oe   = sda_oe_reg;
    assign o_rd_en    = rd_en_reg;
    assign o_rd_addr  = addr_reg;
    assign o_addr_hit = addr_hit_reg;
    assign o_busy     = busy_reg;

endmodule
